// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared widths for the architectural register file and its read ports.
// These are the core-wide constants (register index, data, and ROB index
// widths) that the register file, decoder and reorder buffer all agree on.
// Contents:
//   REG_IDX_WIDTH  - bits in an architectural register index (x0..x31)
//   DATA_WIDTH     - bits in a register value
//   ROB_IDX_WIDTH  - bits in a reorder buffer entry index (rename tag)
//   ROB_IDX_SIZE   - number of reorder buffer entries
//   is_zero_reg()  - true for x0, which is hardwired to zero
package reg_file_pkg;

    localparam int REG_IDX_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam int ROB_IDX_WIDTH = 4;
    localparam int ROB_IDX_SIZE  = 1 << ROB_IDX_WIDTH;

    // x0 never holds state, never becomes busy, and always reads as zero.
    function automatic logic is_zero_reg(input logic [REG_IDX_WIDTH-1:0] idx);
        return (idx == '0);
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// rf_read_port
// One combinational read port of the register file. The top level selects
// the stored entry for the requested index; this block applies the x0 rule
// and the commit bypass, so a source operand whose producer is retiring in
// this very cycle is handed the committed value instead of a stale tag.
// Ports:
//   idx             in   source register index
//   reg_busy        in   stored busy bit of that register
//   reg_tag         in   stored rename tag of that register
//   reg_val         in   stored value of that register
//   commit_en       in   commit strobe from the ROB
//   commit_rob_idx  in   ROB index of the committing entry
//   commit_dest     in   destination register of the committing entry
//   commit_val      in   value being committed
//   busy            out  register still awaits an uncommitted producer
//   dep             out  producer ROB index (meaningful when busy)
//   val             out  register value (meaningful when not busy)
module rf_read_port
    import reg_file_pkg::*;
(
    input  logic [REG_IDX_WIDTH-1:0] idx,
    input  logic                     reg_busy,
    input  logic [ROB_IDX_WIDTH-1:0] reg_tag,
    input  logic [DATA_WIDTH-1:0]    reg_val,
    input  logic                     commit_en,
    input  logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
    input  logic [REG_IDX_WIDTH-1:0] commit_dest,
    input  logic [DATA_WIDTH-1:0]    commit_val,
    output logic                     busy,
    output logic [ROB_IDX_WIDTH-1:0] dep,
    output logic [DATA_WIDTH-1:0]    val
);

    logic commit_hit;

    // The bypass fires only when the committing entry is exactly the
    // producer this register is waiting on. A commit from an older, already
    // superseded producer must not make the register look ready.
    always_comb begin
        commit_hit = commit_en && (commit_dest == idx) && reg_busy
                     && (reg_tag == commit_rob_idx);
    end

    // x0 wins over everything; otherwise the bypass overrides storage.
    // A same-cycle rename is deliberately invisible here, so an instruction
    // reading and writing the same register sees the older producer.
    always_comb begin
        busy = reg_busy;
        dep  = reg_tag;
        val  = reg_val;
        if (is_zero_reg(idx)) begin
            busy = 1'b0;
            dep  = '0;
            val  = '0;
        end else if (commit_hit) begin
            busy = 1'b0;
            val  = commit_val;
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file
// Architectural register file with rename tags. Holds value, busy bit and
// producer tag for every register, takes committed results from the ROB,
// records new rename tags from the decoder, and serves two combinational
// source-operand read ports with commit bypass.
// Ports:
//   clk              in   system clock
//   rst_n_in         in   asynchronous active-low reset
//   rdy_in           in   global ready; state holds while low
//   roll_back_in     in   misprediction flush: clears every busy bit
//   de_rename_en     in   decoder issues an instruction with a destination
//   de_rd_in         in   destination register of that instruction
//   de_rob_idx_in    in   ROB entry allocated to that instruction
//   rs1_idx_in       in   source 1 register index
//   rs2_idx_in       in   source 2 register index
//   rs1/rs2_busy_out out  source awaits an uncommitted producer
//   rs1/rs2_dep_out  out  producer ROB index when busy
//   rs1/rs2_val_out  out  source value when not busy
//   rf_in_en         in   ROB commit strobe
//   rf_rob_idx_in    in   index of the committing ROB entry
//   rf_dest_in       in   committing destination register
//   rf_val_in        in   committed value
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM = 32
) (
    input  logic                     clk,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     roll_back_in,
    input  logic                     de_rename_en,
    input  logic [REG_IDX_WIDTH-1:0] de_rd_in,
    input  logic [ROB_IDX_WIDTH-1:0] de_rob_idx_in,
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx_in,
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx_in,
    output logic                     rs1_busy_out,
    output logic                     rs2_busy_out,
    output logic [ROB_IDX_WIDTH-1:0] rs1_dep_out,
    output logic [ROB_IDX_WIDTH-1:0] rs2_dep_out,
    output logic [DATA_WIDTH-1:0]    rs1_val_out,
    output logic [DATA_WIDTH-1:0]    rs2_val_out,
    input  logic                     rf_in_en,
    input  logic [ROB_IDX_WIDTH-1:0] rf_rob_idx_in,
    input  logic [REG_IDX_WIDTH-1:0] rf_dest_in,
    input  logic [DATA_WIDTH-1:0]    rf_val_in
);

    logic [DATA_WIDTH-1:0]    val_q [REG_NUM];
    logic [ROB_IDX_WIDTH-1:0] tag_q [REG_NUM];
    logic [REG_NUM-1:0]       busy_q;

    logic commit_valid;
    logic rename_valid;
    logic commit_clears;

    // A rename is dropped during rollback: the instruction behind it is on
    // the flushed path. A commit keeps its right to clear busy only if it
    // is the current producer and no newer rename lands on the same
    // register in this cycle.
    always_comb begin
        commit_valid  = rf_in_en && !is_zero_reg(rf_dest_in);
        rename_valid  = de_rename_en && !is_zero_reg(de_rd_in) && !roll_back_in;
        commit_clears = (tag_q[rf_dest_in] == rf_rob_idx_in)
                        && !(rename_valid && (de_rd_in == rf_dest_in));
    end

    // State update. The order of the statements is the priority: commit
    // clear first, rollback wipes all busy bits, and a surviving rename
    // sets busy last. The committed value is written regardless of tags,
    // since commits retire in program order and the latest retired value
    // is the architectural one.
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else if (rdy_in) begin
            if (commit_valid) begin
                val_q[rf_dest_in] <= rf_val_in;
                if (commit_clears) begin
                    busy_q[rf_dest_in] <= 1'b0;
                end
            end
            if (roll_back_in) begin
                busy_q <= '0;
            end
            if (rename_valid) begin
                busy_q[de_rd_in] <= 1'b1;
                tag_q[de_rd_in]  <= de_rob_idx_in;
            end
        end
    end

    rf_read_port u_rs1_port (
        .idx            (rs1_idx_in),
        .reg_busy       (busy_q[rs1_idx_in]),
        .reg_tag        (tag_q[rs1_idx_in]),
        .reg_val        (val_q[rs1_idx_in]),
        .commit_en      (rf_in_en),
        .commit_rob_idx (rf_rob_idx_in),
        .commit_dest    (rf_dest_in),
        .commit_val     (rf_val_in),
        .busy           (rs1_busy_out),
        .dep            (rs1_dep_out),
        .val            (rs1_val_out)
    );

    rf_read_port u_rs2_port (
        .idx            (rs2_idx_in),
        .reg_busy       (busy_q[rs2_idx_in]),
        .reg_tag        (tag_q[rs2_idx_in]),
        .reg_val        (val_q[rs2_idx_in]),
        .commit_en      (rf_in_en),
        .commit_rob_idx (rf_rob_idx_in),
        .commit_dest    (rf_dest_in),
        .commit_val     (rf_val_in),
        .busy           (rs2_busy_out),
        .dep            (rs2_dep_out),
        .val            (rs2_val_out)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
// Self-checking bench for reg_file: a directed vector table walking the
// rename/commit/rollback corner cases, a mid-cycle reset sequence, and a
// randomized phase compared against an array-based reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int RW = ROB_IDX_WIDTH;

    logic            clk = 1'b0;
    logic            rst_n_in;
    logic            rdy_in;
    logic            roll_back_in;
    logic            de_rename_en;
    logic [4:0]      de_rd_in;
    logic [RW-1:0]   de_rob_idx_in;
    logic [4:0]      rs1_idx_in;
    logic [4:0]      rs2_idx_in;
    logic            rs1_busy_out;
    logic            rs2_busy_out;
    logic [RW-1:0]   rs1_dep_out;
    logic [RW-1:0]   rs2_dep_out;
    logic [31:0]     rs1_val_out;
    logic [31:0]     rs2_val_out;
    logic            rf_in_en;
    logic [RW-1:0]   rf_rob_idx_in;
    logic [4:0]      rf_dest_in;
    logic [31:0]     rf_val_in;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one entry per architectural register.
    logic [31:0]   mVal  [32];
    logic          mBusy [32];
    logic [RW-1:0] mTag  [32];

    typedef struct {
        logic          ren;
        logic [4:0]    rd;
        logic [RW-1:0] rtag;
        logic          cen;
        logic [RW-1:0] cidx;
        logic [4:0]    cdest;
        logic [31:0]   cval;
        logic          rb;
        logic          rdy;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic          b1;
        logic [RW-1:0] d1;
        logic [31:0]   v1;
        logic          b2;
        logic [RW-1:0] d2;
        logic [31:0]   v2;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    reg_file #(.REG_NUM(32)) dut (
        .clk           (clk),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .roll_back_in  (roll_back_in),
        .de_rename_en  (de_rename_en),
        .de_rd_in      (de_rd_in),
        .de_rob_idx_in (de_rob_idx_in),
        .rs1_idx_in    (rs1_idx_in),
        .rs2_idx_in    (rs2_idx_in),
        .rs1_busy_out  (rs1_busy_out),
        .rs2_busy_out  (rs2_busy_out),
        .rs1_dep_out   (rs1_dep_out),
        .rs2_dep_out   (rs2_dep_out),
        .rs1_val_out   (rs1_val_out),
        .rs2_val_out   (rs2_val_out),
        .rf_in_en      (rf_in_en),
        .rf_rob_idx_in (rf_rob_idx_in),
        .rf_dest_in    (rf_dest_in),
        .rf_val_in     (rf_val_in)
    );

    function automatic vec_t mk(
        input logic ren, input int rd, input int rtag,
        input logic cen, input int cidx, input int cdest, input logic [31:0] cval,
        input logic rb, input logic rdy, input int rs1, input int rs2,
        input logic b1, input int d1, input logic [31:0] v1,
        input logic b2, input int d2, input logic [31:0] v2);
        vec_t v;
        v.ren = ren;  v.rd = rd[4:0];  v.rtag = rtag[RW-1:0];
        v.cen = cen;  v.cidx = cidx[RW-1:0];  v.cdest = cdest[4:0];  v.cval = cval;
        v.rb = rb;  v.rdy = rdy;  v.rs1 = rs1[4:0];  v.rs2 = rs2[4:0];
        v.b1 = b1;  v.d1 = d1[RW-1:0];  v.v1 = v1;
        v.b2 = b2;  v.d2 = d2[RW-1:0];  v.v2 = v2;
        return v;
    endfunction

    // Drives one cycle's worth of DUT inputs from a vector record.
    task automatic applyStimulus(input vec_t v);
        de_rename_en  = v.ren;
        de_rd_in      = v.rd;
        de_rob_idx_in = v.rtag;
        rf_in_en      = v.cen;
        rf_rob_idx_in = v.cidx;
        rf_dest_in    = v.cdest;
        rf_val_in     = v.cval;
        roll_back_in  = v.rb;
        rdy_in        = v.rdy;
        rs1_idx_in    = v.rs1;
        rs2_idx_in    = v.rs2;
    endtask

    // Compares one read port. dep is only meaningful while busy and val
    // only while not busy, unless 'full' asks for every field.
    task automatic checkOutput(input string name, input logic full,
                               input logic bAct, input logic [RW-1:0] dAct, input logic [31:0] vAct,
                               input logic bExp, input logic [RW-1:0] dExp, input logic [31:0] vExp);
        logic bad;
        bad = (bAct !== bExp);
        if ((full || bExp) && (dAct !== dExp)) bad = 1'b1;
        if ((full || !bExp) && (vAct !== vExp)) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL %s: got busy=%0b dep=%0d val=%08h, expected busy=%0b dep=%0d val=%08h",
                     name, bAct, dAct, vAct, bExp, dExp, vExp);
        end
    endtask

    task automatic driveIdle(input logic [4:0] rs1, input logic [4:0] rs2);
        vec_t v;
        v = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 1, rs1, rs2, 0, 0, 32'h0, 0, 0, 32'h0);
        applyStimulus(v);
    endtask

    // Expected read-port output derived from the register file's rules.
    task automatic modelRead(input logic [4:0] idx, output logic b, output logic [RW-1:0] d,
                             output logic [31:0] v);
        b = mBusy[idx];
        d = mTag[idx];
        v = mVal[idx];
        if (idx == 0) begin
            b = 0; d = 0; v = 0;
        end else if (rf_in_en && rf_dest_in == idx && mBusy[idx] && mTag[idx] == rf_rob_idx_in) begin
            b = 0; v = rf_val_in;
        end
    endtask

    // Advances the model by one clock edge using the currently driven inputs.
    task automatic modelStep();
        bit doRename;
        if (!rdy_in) return;
        doRename = de_rename_en && de_rd_in != 0 && !roll_back_in;
        if (rf_in_en && rf_dest_in != 0) begin
            mVal[rf_dest_in] = rf_val_in;
            if (mTag[rf_dest_in] == rf_rob_idx_in && !(doRename && de_rd_in == rf_dest_in))
                mBusy[rf_dest_in] = 0;
        end
        if (roll_back_in)
            for (int i = 0; i < 32; i++) mBusy[i] = 0;
        if (doRename) begin
            mBusy[de_rd_in] = 1;
            mTag[de_rd_in]  = de_rob_idx_in;
        end
    endtask

    initial begin
        logic          eb;
        logic [RW-1:0] ed;
        logic [31:0]   ev;
        int            r;

        //                  ren rd tag cen cidx cdest cval          rb rdy rs1 rs2  b1 d1 v1            b2 d2 v2
        vecs[0]  = mk(1, 5, 3, 0, 0, 0, 32'h0,        0, 1, 5, 0,  0, 0, 32'h0,        0, 0, 32'h0);
        vecs[1]  = mk(0, 0, 0, 1, 3, 5, 32'hDEADBEEF, 0, 1, 5, 5,  0, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 5, 7,  0, 0, 32'hDEADBEEF, 0, 0, 32'h0);
        vecs[3]  = mk(1, 7, 2, 0, 0, 0, 32'h0,        0, 1, 7, 0,  0, 0, 32'h0,        0, 0, 32'h0);
        vecs[4]  = mk(1, 7, 9, 0, 0, 0, 32'h0,        0, 1, 7, 0,  1, 2, 32'h0,        0, 0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 1, 2, 7, 32'h11,       0, 1, 7, 4,  1, 9, 32'h0,        0, 0, 32'h0);
        vecs[6]  = mk(1, 4, 1, 1, 9, 7, 32'h99,       0, 1, 7, 4,  0, 0, 32'h99,       0, 0, 32'h0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 7, 4,  0, 0, 32'h99,       1, 1, 32'h0);
        vecs[8]  = mk(1, 4, 6, 1, 1, 4, 32'h22,       0, 1, 4, 4,  0, 0, 32'h22,       0, 0, 32'h22);
        vecs[9]  = mk(1, 1, 1, 0, 0, 0, 32'h0,        0, 1, 4, 5,  1, 6, 32'h0,        0, 0, 32'hDEADBEEF);
        vecs[10] = mk(1, 2, 2, 0, 0, 0, 32'h0,        0, 1, 1, 0,  1, 1, 32'h0,        0, 0, 32'h0);
        vecs[11] = mk(1, 3, 3, 0, 0, 0, 32'h0,        0, 1, 2, 0,  1, 2, 32'h0,        0, 0, 32'h0);
        vecs[12] = mk(1, 8, 5, 0, 0, 0, 32'h0,        1, 1, 3, 8,  1, 3, 32'h0,        0, 0, 32'h0);
        vecs[13] = mk(1, 0, 7, 1, 7, 0, 32'h55,       0, 1, 1, 8,  0, 0, 32'h0,        0, 0, 32'h0);
        vecs[14] = mk(1, 9, 4, 0, 0, 0, 32'h0,        0, 0, 0, 3,  0, 0, 32'h0,        0, 0, 32'h0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 9, 4,  0, 0, 32'h0,        0, 0, 32'h22);

        // Reset state
        rst_n_in = 1'b0;
        driveIdle(5'd5, 5'd31);
        #12;
        checkOutput("reset_rs1", 1, rs1_busy_out, rs1_dep_out, rs1_val_out, 0, 0, 32'h0);
        checkOutput("reset_rs2", 1, rs2_busy_out, rs2_dep_out, rs2_val_out, 0, 0, 32'h0);
        @(negedge clk);
        rst_n_in = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_rs1", i), 0, rs1_busy_out, rs1_dep_out, rs1_val_out,
                        vecs[i].b1, vecs[i].d1, vecs[i].v1);
            checkOutput($sformatf("vec%0d_rs2", i), 0, rs2_busy_out, rs2_dep_out, rs2_val_out,
                        vecs[i].b2, vecs[i].d2, vecs[i].v2);
        end

        // Mid-cycle asynchronous reset while strobes are active
        @(negedge clk);
        driveIdle(5'd5, 5'd4);
        de_rename_en = 1; de_rd_in = 5; de_rob_idx_in = 3;
        rf_in_en = 1; rf_dest_in = 5; rf_rob_idx_in = 3; rf_val_in = 32'hCAFEF00D;
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("midreset_rs1", 1, rs1_busy_out, rs1_dep_out, rs1_val_out, 0, 0, 32'h0);
        checkOutput("midreset_rs2", 1, rs2_busy_out, rs2_dep_out, rs2_val_out, 0, 0, 32'h0);
        @(negedge clk);
        driveIdle(5'd5, 5'd0);
        rst_n_in = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_reset_x5", 1, rs1_busy_out, rs1_dep_out, rs1_val_out, 0, 0, 32'h0);

        // Randomized phase against the reference model
        for (int i = 0; i < 32; i++) begin
            mVal[i] = 0; mBusy[i] = 0; mTag[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            de_rename_en  = ($urandom_range(0, 99) < 50);
            de_rd_in      = 5'($urandom_range(0, 7));
            de_rob_idx_in = RW'($urandom);
            rf_in_en      = ($urandom_range(0, 99) < 60);
            rf_dest_in    = 5'($urandom_range(0, 7));
            rf_rob_idx_in = ($urandom_range(0, 1) == 1) ? mTag[rf_dest_in] : RW'($urandom);
            rf_val_in     = $urandom;
            roll_back_in  = ($urandom_range(0, 99) < 5);
            rdy_in        = ($urandom_range(0, 99) < 90);
            r             = $urandom_range(0, 3);
            rs1_idx_in    = (r == 0) ? rf_dest_in : 5'($urandom_range(0, 7));
            rs2_idx_in    = 5'($urandom_range(0, 7));
            #1;
            modelRead(rs1_idx_in, eb, ed, ev);
            checkOutput($sformatf("rand%0d_rs1", n), 0, rs1_busy_out, rs1_dep_out, rs1_val_out, eb, ed, ev);
            modelRead(rs2_idx_in, eb, ed, ev);
            checkOutput($sformatf("rand%0d_rs2", n), 0, rs2_busy_out, rs2_dep_out, rs2_val_out, eb, ed, ev);
            modelStep();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the out-of-order RISC-V core. It is the receiving end of the reorder buffer's commit interface: it writes committed results into x1..x31 and clears each register's pending-producer tag when the matching ROB entry retires. It also records new rename tags from the decoder and serves two combinational read ports, so the decoder learns each source operand's value or the ROB index that will produce it.

## Interface
Parameters:
- `REG_NUM`, default 32: number of architectural registers; x0 is hardwired to zero.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst_n_in`  in  1  reset, asynchronous and active-low.
- `rdy_in`  in  1  global ready; state holds while low.
- `roll_back_in`  in  1  misprediction flush from the ROB.
- `de_rename_en`  in  1  decoder issues an instruction with a destination.
- `de_rd_in`  in  5  destination register of the issuing instruction.
- `de_rob_idx_in`  in  `ROB_IDX_WIDTH`  ROB entry allocated to that instruction.
- `rs1_idx_in`, `rs2_idx_in`  in  5  source register indices.
- `rs1_busy_out`, `rs2_busy_out`  out  1  register awaits an uncommitted producer.
- `rs1_dep_out`, `rs2_dep_out`  out  `ROB_IDX_WIDTH`  producer ROB index; meaningful only when busy.
- `rs1_val_out`, `rs2_val_out`  out  32  architectural value; meaningful only when not busy.
- `rf_in_en`  in  1  ROB commit strobe.
- `rf_rob_idx_in`  in  `ROB_IDX_WIDTH`  index of the committing ROB entry.
- `rf_dest_in`  in  5  committing destination register.
- `rf_val_in`  in  32  committed value.

## Operation
Per-register state is `val[32]`, `busy`, and `tag[ROB_IDX_WIDTH]`.

Reset (asynchronous, while `rst_n_in` is 0):
- All `val`, `busy`, and `tag` are cleared to 0.
- The read outputs are combinational, so for index 0 they read busy=0, dep=0, val=0.

Commit, when `rf_in_en` is high and `rf_dest_in` is not 0:
- `val[rf_dest_in]` is written with `rf_val_in` unconditionally.
- `busy` is cleared only if `tag[rf_dest_in]` equals `rf_rob_idx_in` and there is no same-cycle rename of the same register.

Rename, when `de_rename_en` is high, `de_rd_in` is not 0, and `roll_back_in` is low:
- `busy[de_rd_in]` is set to 1 and `tag[de_rd_in]` is set to `de_rob_idx_in`.
- A rename overrides a same-cycle commit to the same register: busy stays 1 with the new tag, and the value is still written.

Rollback (`roll_back_in` high):
- All `busy` bits clear at the next edge.
- A rename in the same cycle is ignored.
- A commit in the same cycle still writes its value.

Read ports (combinational, both identical):
- If the index is 0, output busy=0 and val=0.
- Else, if `rf_in_en` is high, `rf_dest_in` equals the index, the register is busy, and `tag` equals `rf_rob_idx_in`: commit bypass, output busy=0 and val=`rf_val_in`.
- Else output the stored `busy`, `tag`, and `val`.
- A same-cycle rename is never forwarded to the read ports. An instruction with rs1 equal to rd therefore sees the older producer.

When `rdy_in` is 0, no state updates occur. The read outputs remain valid.

x0 is never written and never becomes busy.

## Timing
- Read ports: zero latency, purely combinational from the indices and the commit bus.
- Rename and commit: take effect at the rising edge that samples them and are visible on the reads in the next cycle.
- No handshake: every strobe is single-cycle, and the file always accepts.
- Asynchronous reset: takes effect immediately, including mid-cycle while strobes are active.
- `ROB_IDX_WIDTH` wrap-around is irrelevant, because tags are compared for equality only.

## Structure
- `REG_IDX_WIDTH`, `DATA_WIDTH`, `ROB_IDX_WIDTH`, and `ROB_IDX_SIZE` come from the shared `param.v`; no new constants are added.
- A sub-module `rf_read_port` holds the bypass mux and is instantiated twice.
- The top level holds the storage arrays and the update logic.

## Test plan
- **Reset:** drive `rst_n_in`=0 mid-cycle with `rf_in_en`=1 → all reads return busy=0, val=0, dep=0 immediately, and x5 stays 0 after release.
- **Rename, then matching commit:** rename x5 with tag 3; next cycle commit idx=3, dest=5, val=0xDEADBEEF.
  - In the commit cycle, rs1=5 reads busy=0, val=0xDEADBEEF (bypass).
  - In the following cycle, the same result comes from storage.
- **Stale commit:** rename x7 to tag 2, then rename x7 to tag 9, then commit idx=2, val=0x11.
  - x7 val becomes 0x11, but busy stays 1 with dep=9.
  - A commit of idx=9 then clears busy.
- **Same-cycle rename and commit on x4:** x4 previously had tag 1; commit idx=1, val=0x22 while renaming x4 to tag 6 → next cycle x4 reads busy=1, dep=6, val=0x22.
- **Rollback:** x1, x2, x3 busy; assert `roll_back_in` with a rename of x8 → next cycle all busy=0, x8 not busy, values unchanged.
- **x0 and rdy_in:**
  - Rename or commit to x0 → x0 reads busy=0, val=0.
  - A rename of x9 while `rdy_in`=0 → x9 remains not busy.
